inst_fetch_buf: RTL and testbench

Parametrised fetch buffer between the instruction-fetch stage and the decode stage. It replaces the single-entry IF/ID latch with a DEPTH-entry FIFO of (pc, inst) pairs that uses valid/ready handshakes on both sides. Fetch can run ahead of decode stalls, and a single-cycle flush discards all buffered instructions on a branch or exception redirect. While the buffer is empty, decode sees an all-zero bubble.

---
 rtl/inst_fetch_buf_pkg.sv | 10 +
 rtl/inst_fetch_buf.sv | 74 +++++++
 tb/tb_inst_fetch_buf.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_buf_pkg.sv
// Shared constants for the fetch buffer: reset level, bubble words, default widths.
package inst_fetch_buf_pkg;

  localparam logic        RST_ENABLE = 1'b1;
  localparam int          DEF_ADDR_W = 32;
  localparam int          DEF_INST_W = 32;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] NOP_INST   = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_buf.sv
// DEPTH-entry (pc, inst) FIFO between fetch and decode with valid/ready on both
// sides and a single-cycle flush; decode sees an all-zero bubble when empty.
module inst_fetch_buf
  import inst_fetch_buf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INST_W = DEF_INST_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              push;
  logic              pop;
  logic              clear;

  // Handshakes depend only on the registered count, so a full buffer refuses
  // input even if decode pops in the same cycle.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign clear     = (rst == RST_ENABLE) | flush;

  assign out_pc   = out_valid ? pc_mem[rptr]   : ADDR_W'(ZERO_WORD);
  assign out_inst = out_valid ? inst_mem[rptr] : INST_W'(NOP_INST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read while count marks it valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      pc_mem[wptr]   <= in_pc;
      inst_mem[wptr] <= in_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Self-checking bench for inst_fetch_buf: queue scoreboard checked every cycle,
// a vector table for stall/fill/flush, and hand sequences for reset and wrap.
module tb_inst_fetch_buf;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc = '0;
  logic [INST_W-1:0] in_inst = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic [CNT_W-1:0]  count;

  inst_fetch_buf #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  typedef struct {
    logic              v;
    logic [ADDR_W-1:0] pc;
    logic              ready;
    logic              fl;
    int                exp_count;
    logic              exp_in_ready;
    logic              exp_out_valid;
    logic [ADDR_W-1:0] exp_pc;
  } vec_t;

  entry_t sb_q[$];
  bit     sb_on = 1'b0;
  int     n_tests = 0;
  int     n_fail  = 0;

  function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] pc);
    return pc ^ 32'h2401_A5A5;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at posedge+1, compare against the scoreboard on the
  // falling edge, update the model for the coming edge, return at posedge+1.
  task automatic cycle(input logic r, input logic fl, input logic v,
                       input logic [ADDR_W-1:0] pc, input logic rdy);
    bit do_push, do_pop;
    rst = r; flush = fl; in_valid = v; in_pc = pc; in_inst = inst_of(pc); out_ready = rdy;
    @(negedge clk);
    if (sb_on) begin
      check("sb_count", 64'(count), 64'(sb_q.size()));
      check("sb_in_ready", 64'(in_ready), 64'(sb_q.size() != DEPTH));
      check("sb_out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
        check("sb_out_pc", 64'(out_pc), 64'(sb_q[0].pc));
        check("sb_out_inst", 64'(out_inst), 64'(sb_q[0].inst));
      end else begin
        check("sb_bubble_pc", 64'(out_pc), 64'd0);
        check("sb_bubble_inst", 64'(out_inst), 64'd0);
      end
    end
    if (r || fl) begin
      sb_q.delete();
    end else begin
      do_pop  = (sb_q.size() != 0) && rdy;
      do_push = v && (sb_q.size() != DEPTH);
      if (do_pop) void'(sb_q.pop_front());
      if (do_push) sb_q.push_back('{pc: pc, inst: inst_of(pc)});
    end
    @(posedge clk);
    #1;
    if (r) sb_on = 1'b1;
  endtask

  vec_t vecs[14];

  initial begin
    // Fill under stall, drain in order, push/pop at count 2 and 4, flush with push.
    vecs[0]  = '{1'b1, 32'h00, 1'b0, 1'b0, 1, 1'b1, 1'b1, 32'h00};
    vecs[1]  = '{1'b1, 32'h04, 1'b0, 1'b0, 2, 1'b1, 1'b1, 32'h00};
    vecs[2]  = '{1'b1, 32'h08, 1'b0, 1'b0, 3, 1'b1, 1'b1, 32'h00};
    vecs[3]  = '{1'b1, 32'h0C, 1'b0, 1'b0, 4, 1'b0, 1'b1, 32'h00};
    vecs[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 4, 1'b0, 1'b1, 32'h00};
    vecs[5]  = '{1'b0, 32'h00, 1'b1, 1'b0, 3, 1'b1, 1'b1, 32'h04};
    vecs[6]  = '{1'b0, 32'h00, 1'b1, 1'b0, 2, 1'b1, 1'b1, 32'h08};
    vecs[7]  = '{1'b1, 32'h20, 1'b1, 1'b0, 2, 1'b1, 1'b1, 32'h0C};
    vecs[8]  = '{1'b1, 32'h24, 1'b1, 1'b0, 2, 1'b1, 1'b1, 32'h20};
    vecs[9]  = '{1'b1, 32'h28, 1'b0, 1'b0, 3, 1'b1, 1'b1, 32'h20};
    vecs[10] = '{1'b1, 32'h2C, 1'b0, 1'b0, 4, 1'b0, 1'b1, 32'h20};
    vecs[11] = '{1'b1, 32'h30, 1'b1, 1'b0, 3, 1'b1, 1'b1, 32'h24};
    vecs[12] = '{1'b1, 32'h34, 1'b1, 1'b1, 0, 1'b1, 1'b0, 32'h00};
    vecs[13] = '{1'b0, 32'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 32'h00};

    #1;
    // Reset for two cycles with fetch still presenting a pair.
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0BAD, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0BAD, 1'b1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_out_inst", 64'(out_inst), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Pass-through with decode ready.
    cycle(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
    check("pt_out_valid", 64'(out_valid), 64'd1);
    check("pt_out_pc", 64'(out_pc), 64'h100);
    check("pt_out_inst", 64'(out_inst), 64'(inst_of(32'h100)));
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("pt_drain_valid", 64'(out_valid), 64'd0);
    check("pt_drain_inst", 64'(out_inst), 64'd0);

    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, vecs[i].fl, vecs[i].v, vecs[i].pc, vecs[i].ready);
      check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_in_ready));
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_out_valid));
      check($sformatf("vec%0d_out_pc", i), 64'(out_pc), 64'(vecs[i].exp_pc));
      check($sformatf("vec%0d_out_inst", i), 64'(out_inst),
            vecs[i].exp_out_valid ? 64'(inst_of(vecs[i].exp_pc)) : 64'd0);
    end

    // Pointer wrap: back-to-back push/pop must stream with no bubble.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 32'h200 + 32'(4 * k), 1'b1);
      check($sformatf("wrap%0d_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("wrap%0d_pc", k), 64'(out_pc), 64'(32'h200 + 32'(4 * k)));
      check($sformatf("wrap%0d_count", k), 64'(count), 64'd1);
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_drain_valid", 64'(out_valid), 64'd0);

    // Reset asserted mid-stream discards buffered entries.
    cycle(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h304, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h308, 1'b1);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_out_pc", 64'(out_pc), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    cycle(1'b0, 1'b0, 1'b1, 32'h400, 1'b0);
    check("post_rst_pc", 64'(out_pc), 64'h400);

    // Randomised traffic against the scoreboard.
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
            32'h1000 + 32'(4 * i), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
